output_display: RTL and testbench
=================================

Name: output_display

Overview:
- Display stage directly downstream of the output register.
- Takes the output register value and drives a multiplexed 7-segment display, replacing the external decode EEPROM.
- A sequential double-dabble converter turns the binary value into BCD, with an optional two's-complement signed mode.
- A scan counter time-multiplexes the digits; the leftmost digit is reserved for the sign.

Parameters:
- N, 8, data width of the value being displayed.
- DIGITS, 4, number of display digits; digit DIGITS-1 is the sign position. Requires DIGITS-1 >= decimal digits of 2^N-1.
- SCAN_DIV, 16, clk cycles each digit stays lit; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- val  input  N  output register contents.
- upd  input  1  one-cycle update strobe: oi registered by one clk in the top level, so val is already stable.
- sgn  input  1  1 = treat val as two's complement; sampled together with val.
- seg  output 7  segment drive, active-high; bit0=a … bit6=g.
- dig_  output DIGITS  digit select, active-low one-hot; bit0 = rightmost (units) digit.
- busy  output 1  conversion in progress.

Behaviour:
- Reset (async, clr=1):
  - State IDLE; busy=0.
  - Shown BCD=0, neg=0, pending=0.
  - Scan index=0, prescaler=0.
  - dig_ = ~1 (only digit 0 enabled), seg=7'h3F (shows "0").
- Capture, on an edge in IDLE with upd=1:
  - mag = (sgn & val[N-1]) ? -val : val, computed N bits wide, unsigned. Example: 8'h80 gives 128.
  - neg_next = sgn & val[N-1].
  - Go to CONV with shift counter=0 and busy=1 from the next cycle.
- CONV, one step per edge:
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd, mag} left by 1 and increment the counter.
- After exactly N CONV edges:
  - Shown BCD and neg are updated on the N-th edge and the state returns to IDLE.
  - busy is high for exactly N cycles; the new display is valid N+1 edges after the capture edge.
- upd while busy:
  - val/sgn are stored in a pending register and pending=1; if several arrive, the last one wins.
  - The conversion in flight still completes and its result is shown.
  - On the completion edge, if pending=1, the pending value is captured instead of going idle, so busy stays high and pending clears.
- upd on the completion edge with pending=0: treated as a capture on that edge (no idle gap).
- Display is glitch-free: shown BCD/neg change only on completion edges, never mid-conversion.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, the scan index goes to (index+1) mod DIGITS.
  - dig_ and seg are registered and change on the same edge.
- Digit content:
  - Digit 0 always shows its BCD value.
  - Digits 1..DIGITS-2 are blank (seg=0) if they and all higher BCD digits are 0 (leading-zero blanking).
  - Digit DIGITS-1 shows minus (7'h40) if neg, else blank.
- Segment codes 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Scan runs continuously, independent of conversion state.
- clr mid-conversion aborts the conversion, drops pending, and returns everything to reset values immediately.

Decomposition:
- Package display_pkg holds:
  - the segment constant array for 0-9;
  - SEG_BLANK and SEG_MINUS;
  - the state enum {IDLE, CONV};
  - a function for the BCD width, ceil-derived as (DIGITS-1)*4.
- Sub-module bin2bcd_seq holds the double-dabble FSM:
  - inputs: start, mag;
  - outputs: bcd, done, busy.
- output_display holds the signed pre-processing, the pending register, the scan logic and the segment decode.

Test Plan:
- Reset, hold clr=1 for 3 cycles then release → busy=0, dig_=4'b1110, seg=3F; the scan reaches digit 1 after 16 edges with seg=00.
- Unsigned: upd with val=8'hFF, sgn=0 → busy=1 for 8 cycles; then digits 3..0 show blank,2,5,5 (00,5B,6D,6D).
- Signed minimum: val=8'h80, sgn=1 → digits show minus,1,2,8 (40,06,5B,7F).
- Signed −1 with blanking: val=8'hFF, sgn=1 → digits show minus,blank,blank,1 (40,00,00,06).
- Overlap: upd val=8'd42, then upd val=8'd7 on cycle 3 and 8'd9 on cycle 5 → 42 is shown after edge 8; the conversion of 9 starts on the same edge and 9 is shown 8 edges later; 7 is never shown.
- Reset mid-conversion: clr on cycle 4 of a conversion of 200 → display shows 0, busy=0, pending cleared; a fresh upd of 5 shows 5 after 8 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the output display stage.
// Segment codes are active-high, bit0=a .. bit6=g.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // One BCD nibble per non-sign digit
  function automatic int bcd_w(input int digits);
    return (digits - 1) * 4;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/output_display_if.sv
// Bus between the output register and the display stage.
// master drives value/strobe, slave drives the display pins.
interface output_display_if #(
  parameter int N      = 8,
  parameter int DIGITS = 4
) ();

  logic [N-1:0]      val;
  logic              upd;
  logic              sgn;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_;
  logic              busy;

  modport master (
    output val, upd, sgn,
    input  seg, dig_, busy
  );

  modport slave (
    input  val, upd, sgn,
    output seg, dig_, busy
  );

endinterface

// File: rtl/output_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock.
// bcd and done are combinational on the final step edge.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int N  = 8,
  parameter int BW = 12
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [N-1:0]  mag,
  output logic [BW-1:0] bcd,
  output logic          done,
  output logic          busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e         st;
  logic [BW-1:0]  acc;
  logic [BW-1:0]  adj;
  logic [N-1:0]   sh;
  logic [CW-1:0]  cnt;
  logic [BW+N-1:0] nxt;
  logic           last;

  always_comb begin
    adj = acc;
    for (int i = 0; i < BW / 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign nxt  = {adj, sh} << 1;
  assign last = (st == CONV) && (cnt == CW'(N - 1));

  assign bcd  = nxt[BW+N-1:N];
  assign done = last;
  assign busy = (st == CONV);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st  <= IDLE;
      acc <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (start) begin
      st  <= CONV;
      acc <= '0;
      sh  <= mag;
      cnt <= '0;
    end else if (st == CONV) begin
      acc <= nxt[BW+N-1:N];
      sh  <= nxt[N-1:0];
      cnt <= cnt + 1'b1;
      if (last)
        st <= IDLE;
    end
  end

endmodule

// File: rtl/output_display.sv
// Display stage: signed magnitude, pending update, BCD convert,
// and a multiplexed 7-segment scan with leading-zero blanking.
module output_display
  import display_pkg::*;
#(
  parameter int N        = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic clk,
  input  logic clr,
  output_display_if.slave bus
);

  localparam int BW = bcd_w(DIGITS);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          pend;
  logic          pend_sgn;
  logic [N-1:0]  pend_val;
  logic          conv_neg;
  logic          shown_neg;
  logic [BW-1:0] shown_bcd;

  logic          start;
  logic          done;
  logic          busy;
  logic          use_pend;
  logic          st_sgn;
  logic          neg_n;
  logic [N-1:0]  st_val;
  logic [N-1:0]  mag;
  logic [BW-1:0] bcd;

  // A queued update takes the completion edge over a fresh strobe
  assign use_pend = done & pend;
  assign start    = use_pend | (bus.upd & (~busy | done));
  assign st_val   = use_pend ? pend_val : bus.val;
  assign st_sgn   = use_pend ? pend_sgn : bus.sgn;
  assign neg_n    = st_sgn & st_val[N-1];
  assign mag      = neg_n ? -st_val : st_val;

  bin2bcd_seq #(
    .N  (N),
    .BW (BW)
  ) u_conv (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .mag   (mag),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy)
  );

  assign bus.busy = busy;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend     <= 1'b0;
      pend_sgn <= 1'b0;
      pend_val <= '0;
    end else if (use_pend) begin
      pend <= bus.upd;
      if (bus.upd) begin
        pend_val <= bus.val;
        pend_sgn <= bus.sgn;
      end
    end else if (busy && bus.upd && !done) begin
      pend     <= 1'b1;
      pend_val <= bus.val;
      pend_sgn <= bus.sgn;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      conv_neg  <= 1'b0;
      shown_neg <= 1'b0;
      shown_bcd <= '0;
    end else begin
      if (done) begin
        shown_bcd <= bcd;
        shown_neg <= conv_neg;
      end
      if (start)
        conv_neg <= neg_n;
    end
  end

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_n;
  logic              wrap;
  logic [DIGITS-2:0] nz;
  logic              run;
  logic [6:0]        seg_n;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] dig_r;

  assign wrap  = (pre == PW'(SCAN_DIV - 1));
  assign idx_n = !wrap ? idx :
                 (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

  // nz[i]: digit i or any higher magnitude digit is non-zero
  always_comb begin
    nz  = '0;
    run = 1'b0;
    for (int i = DIGITS - 2; i >= 0; i--) begin
      run   = run | (shown_bcd[4*i +: 4] != 4'd0);
      nz[i] = run;
    end
  end

  always_comb begin
    seg_n = SEG_BLANK;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (idx_n == IW'(i))
        seg_n = (i == 0 || nz[i]) ?
                seg_of(shown_bcd[4*i +: 4]) : SEG_BLANK;
    end
    if (idx_n == IW'(DIGITS - 1))
      seg_n = shown_neg ? SEG_MINUS : SEG_BLANK;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre   <= '0;
      idx   <= '0;
      seg_r <= SEG_DIGIT[0];
      dig_r <= ~DIGITS'(1);
    end else begin
      pre   <= wrap ? '0 : pre + 1'b1;
      idx   <= idx_n;
      seg_r <= seg_n;
      dig_r <= ~(DIGITS'(1) << idx_n);
    end
  end

  assign bus.seg  = seg_r;
  assign bus.dig_ = dig_r;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: stimulus queues timed
// expectations, a negedge monitor pops and compares them.
module tb_output_display;

  localparam int N        = 8;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;

  localparam int K_DISP = 0;
  localparam int K_BUSY = 1;
  localparam int K_DIG  = 2;
  localparam int K_SEG  = 3;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  output_display_if #(.N(N), .DIGITS(DIGITS)) bus ();

  output_display #(
    .N        (N),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [27:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_check(input chk_t c);
    logic [27:0] act;
    logic [27:0] ex;
    bit          ok;
    int          li;
    n_chk++;
    act = '0;
    ex  = c.exp;
    ok  = 1'b1;
    li  = -1;
    case (c.kind)
      K_BUSY: act = 28'(bus.busy);
      K_DIG:  act = 28'(bus.dig_);
      K_SEG:  act = 28'(bus.seg);
      default: begin
        case (bus.dig_)
          4'b1110: li = 0;
          4'b1101: li = 1;
          4'b1011: li = 2;
          4'b0111: li = 3;
          default: li = -1;
        endcase
        act = {bus.dig_, 17'd0, bus.seg};
        if (li < 0) begin
          ok = 1'b0;
          ex = {4'hF, 17'd0, 7'h00};
        end else begin
          ex = 28'(c.exp[7*li +: 7]);
          act = 28'(bus.seg);
        end
      end
    endcase
    if (c.cyc != cyc) ok = 1'b0;
    if (ok && act == ex) n_pass++;
    else
      $display("FAIL %s cyc=%0d digit=%0d: got %h want %h",
               c.name, cyc, li, act, ex);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        do_check(q[i]);
        q.delete(i);
      end
    end
  end

  task automatic push(input string nm, input int at,
                      input int kind, input logic [27:0] e);
    chk_t c;
    c.cyc  = at;
    c.kind = kind;
    c.exp  = e;
    c.name = nm;
    q.push_back(c);
  endtask

  // One sample per digit slot across a full scan period
  task automatic disp4(input string nm, input int at,
                       input logic [27:0] e);
    for (int j = 0; j < DIGITS; j++)
      push(nm, at + SCAN_DIV * j, K_DISP, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic upd_pulse(input logic [7:0] v, input logic s);
    bus.val = v;
    bus.sgn = s;
    bus.upd = 1'b1;
    step(1);
    bus.upd = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++)
      step(1);
    while (q.size() > 0) begin
      n_chk++;
      $display("FAIL timeout %s: got pending want done",
               q[0].name);
      void'(q.pop_front());
    end
  endtask

  task automatic conv_test(input string nm, input logic [7:0] v,
                           input logic s, input logic [27:0] e);
    int k;
    k = cyc;
    push({nm, "_busy0"}, k,     K_BUSY, 28'd0);
    push({nm, "_busy1"}, k + 1, K_BUSY, 28'd1);
    push({nm, "_busy8"}, k + 8, K_BUSY, 28'd1);
    push({nm, "_idle"},  k + 9, K_BUSY, 28'd0);
    disp4(nm, k + 10, e);
    upd_pulse(v, s);
    drain();
  endtask

  initial begin
    int k;
    clr     = 1'b1;
    bus.val = '0;
    bus.sgn = 1'b0;
    bus.upd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    k = cyc;
    push("rst_busy", k,      K_BUSY, 28'd0);
    push("rst_dig",  k,      K_DIG,  28'(4'b1110));
    push("rst_seg",  k,      K_SEG,  28'(7'h3F));
    push("scan_d0",  k + 15, K_DIG,  28'(4'b1110));
    push("scan_s0",  k + 15, K_SEG,  28'(7'h3F));
    push("scan_d1",  k + 16, K_DIG,  28'(4'b1101));
    push("scan_s1",  k + 16, K_SEG,  28'(7'h00));
    drain();
    step(3);

    conv_test("u255", 8'hFF, 1'b0, {7'h00, 7'h5B, 7'h6D, 7'h6D});
    conv_test("s128", 8'h80, 1'b1, {7'h40, 7'h06, 7'h5B, 7'h7F});
    conv_test("sm1",  8'hFF, 1'b1, {7'h40, 7'h00, 7'h00, 7'h06});

    k = cyc;
    push("ovl42a",   k + 10, K_DISP, {7'h00, 7'h00, 7'h66, 7'h5B});
    push("ovl42b",   k + 17, K_DISP, {7'h00, 7'h00, 7'h66, 7'h5B});
    push("ovl_b9",   k + 9,  K_BUSY, 28'd1);
    push("ovl_b10",  k + 10, K_BUSY, 28'd1);
    push("ovl_b16",  k + 16, K_BUSY, 28'd1);
    push("ovl_idle", k + 17, K_BUSY, 28'd0);
    disp4("ovl9", k + 18, {7'h00, 7'h00, 7'h00, 7'h6F});
    upd_pulse(8'd42, 1'b0);
    step(1);
    upd_pulse(8'd7, 1'b0);
    step(1);
    upd_pulse(8'd9, 1'b0);
    drain();

    k = cyc;
    push("clr_busy", k + 3,  K_BUSY, 28'd0);
    push("clr_dig",  k + 3,  K_DIG,  28'(4'b1110));
    push("clr_seg",  k + 3,  K_SEG,  28'(7'h3F));
    push("r5_busy",  k + 7,  K_BUSY, 28'd1);
    push("r5_b14",   k + 14, K_BUSY, 28'd1);
    push("r5_idle",  k + 15, K_BUSY, 28'd0);
    push("r5_nopnd", k + 16, K_BUSY, 28'd0);
    disp4("r5", k + 16, {7'h00, 7'h00, 7'h00, 7'h6D});
    upd_pulse(8'd200, 1'b0);
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);
    upd_pulse(8'd5, 1'b0);
    drain();

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
